// File: rtl/user_input_loader.sv
// user_input_loader: conditions raw key and button inputs, then assembles a
// four-digit BCD entry for the memorization game. The entry is committed
// (ready) when the player presses enter on a full entry during the input phase.
module user_input_loader #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int NUM_DIGITS      = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    inputEnable,
  input  logic [3:0]              keyCode,
  input  logic                    keyValid,
  input  logic                    btnEnter,
  input  logic                    btnClear,
  output logic [4*NUM_DIGITS-1:0] userInt,
  output logic [2:0]              digitCount,
  output logic                    ready
);

  localparam int W     = 4 * NUM_DIGITS;
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [2:0]       CNT_LAST = 3'(NUM_DIGITS - 1);

  // Bit positions of the three conditioned inputs
  localparam int KEY   = 0;
  localparam int ENTER = 1;
  localparam int CLEAR = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ENTRY = 2'd1,
    ST_FULL  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  logic [2:0]       raw_s;
  logic [2:0]       sync1_q, sync2_q;
  logic [2:0]       deb_q, deb_d;
  logic [2:0]       deb_prev_q;
  logic [2:0]       ev_q;
  logic [CNT_W-1:0] cnt_q [3];
  logic [CNT_W-1:0] cnt_d [3];

  state_e         state_q, state_d;
  logic [W-1:0]   userInt_q, userInt_d;
  logic [2:0]     digitCount_q, digitCount_d;
  logic           ready_q, ready_d;

  logic           key_ev_s, enter_ev_s, clear_ev_s, key_ok_s;

  assign raw_s = {btnClear, btnEnter, keyValid};

  // Two-flop synchronizers for the asynchronous key and button levels
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 3'b000;
      sync2_q <= 3'b000;
    end else begin
      sync1_q <= raw_s;
      sync2_q <= sync1_q;
    end
  end

  // Debounce counters: run while the input disagrees with the stable level
  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < 3; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          deb_d[i] = ~deb_q[i];
          cnt_d[i] = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end else begin
        cnt_d[i] = '0;
      end
    end
  end

  // Debounced levels and registered one-cycle press events
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      deb_q      <= 3'b000;
      deb_prev_q <= 3'b000;
      ev_q       <= 3'b000;
      for (int i = 0; i < 3; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      ev_q       <= deb_q & ~deb_prev_q;
      for (int i = 0; i < 3; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign key_ev_s   = ev_q[KEY];
  assign enter_ev_s = ev_q[ENTER];
  assign clear_ev_s = ev_q[CLEAR];
  assign key_ok_s   = key_ev_s && (keyCode <= 4'd9);

  // State and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      userInt_q    <= '0;
      digitCount_q <= 3'd0;
      ready_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      userInt_q    <= userInt_d;
      digitCount_q <= digitCount_d;
      ready_q      <= ready_d;
    end
  end

  // Next state: phase exit beats clear, clear beats enter, enter beats key
  always_comb begin
    state_d = state_q;
    if (state_q == ST_IDLE) begin
      state_d = inputEnable ? ST_ENTRY : ST_IDLE;
    end else if (!inputEnable) begin
      state_d = ST_IDLE;
    end else if (clear_ev_s) begin
      state_d = ST_ENTRY;
    end else begin
      case (state_q)
        ST_ENTRY: begin
          if (!enter_ev_s && key_ok_s && (digitCount_q == CNT_LAST)) begin
            state_d = ST_FULL;
          end else begin
            state_d = ST_ENTRY;
          end
        end
        ST_FULL: begin
          state_d = enter_ev_s ? ST_DONE : ST_FULL;
        end
        ST_DONE: begin
          state_d = ST_DONE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Output datapath: digit shifting, counting and commit flag
  always_comb begin
    userInt_d    = userInt_q;
    digitCount_d = digitCount_q;
    ready_d      = ready_q;
    if (state_q == ST_IDLE) begin
      if (inputEnable) begin
        userInt_d    = '0;
        digitCount_d = 3'd0;
        ready_d      = 1'b0;
      end else begin
        ready_d      = ready_q;
      end
    end else if (!inputEnable) begin
      ready_d = 1'b0;
    end else if (clear_ev_s) begin
      userInt_d    = '0;
      digitCount_d = 3'd0;
      ready_d      = 1'b0;
    end else begin
      case (state_q)
        ST_ENTRY: begin
          if (!enter_ev_s && key_ok_s) begin
            userInt_d    = {userInt_q[W-5:0], keyCode};
            digitCount_d = digitCount_q + 3'd1;
          end else begin
            userInt_d    = userInt_q;
          end
        end
        ST_FULL: begin
          if (enter_ev_s) begin
            ready_d = 1'b1;
          end else begin
            ready_d = 1'b0;
          end
        end
        ST_DONE: begin
          ready_d = 1'b1;
        end
        default: begin
          ready_d = 1'b0;
        end
      endcase
    end
  end

  assign userInt    = userInt_q;
  assign digitCount = digitCount_q;
  assign ready      = ready_q;

endmodule

// File: tb/tb_user_input_loader.sv
// Bench for user_input_loader: reset checks, a table of key/button operations
// with expected results queued in a scoreboard, and hand-written corner cases.
module tb_user_input_loader;

  localparam int DB = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        inputEnable;
  logic [3:0]  keyCode;
  logic        keyValid;
  logic        btnEnter;
  logic        btnClear;
  logic [15:0] userInt;
  logic [2:0]  digitCount;
  logic        ready;

  always #5 clk = ~clk;

  user_input_loader #(.DEBOUNCE_CYCLES(DB), .NUM_DIGITS(4)) dut (
    .clk(clk), .rst(rst), .inputEnable(inputEnable), .keyCode(keyCode),
    .keyValid(keyValid), .btnEnter(btnEnter), .btnClear(btnClear),
    .userInt(userInt), .digitCount(digitCount), .ready(ready)
  );

  typedef enum int {OP_KEY, OP_ENTER, OP_ENTER_TIMED, OP_CLEAR, OP_BOTH,
                    OP_GLITCH, OP_BOUNCE, OP_EN0, OP_EN1} op_e;

  typedef struct {
    op_e         op;
    logic [3:0]  code;
    logic [15:0] exp_int;
    logic [2:0]  exp_cnt;
    logic        exp_rdy;
  } vec_t;

  typedef struct packed {
    logic [15:0] i;
    logic [2:0]  c;
    logic        r;
  } exp_t;

  vec_t vecs[$];
  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(op_e op, logic [3:0] code, logic [15:0] ei, logic [2:0] ec, logic er);
    vec_t v;
    v.op = op; v.code = code; v.exp_int = ei; v.exp_cnt = ec; v.exp_rdy = er;
    return v;
  endfunction

  task automatic press_key(input logic [3:0] code);
    keyCode = code;
    keyValid = 1'b1;
    tick(12);
    keyValid = 1'b0;
    tick(12);
  endtask

  task automatic apply(input vec_t v);
    int rise;
    case (v.op)
      OP_KEY: press_key(v.code);
      OP_ENTER: begin
        btnEnter = 1'b1; tick(12); btnEnter = 1'b0; tick(12);
      end
      OP_ENTER_TIMED: begin
        btnEnter = 1'b1;
        rise = -1;
        for (int c = 1; c <= 20; c++) begin
          @(negedge clk);
          if (ready === 1'b1 && rise < 0) rise = c;
        end
        check("enter_to_ready_cycles", rise, 32'd8);
        btnEnter = 1'b0; tick(12);
      end
      OP_CLEAR: begin
        btnClear = 1'b1; tick(12); btnClear = 1'b0; tick(12);
      end
      OP_BOTH: begin
        btnEnter = 1'b1; btnClear = 1'b1; tick(12);
        btnEnter = 1'b0; btnClear = 1'b0; tick(12);
      end
      OP_GLITCH: begin
        keyCode = v.code; keyValid = 1'b1; tick(3); keyValid = 1'b0; tick(12);
      end
      OP_BOUNCE: begin
        keyCode = v.code;
        for (int k = 0; k < 10; k++) begin
          keyValid = ~keyValid;
          tick(1);
        end
        press_key(v.code);
      end
      OP_EN0: begin
        inputEnable = 1'b0; tick(1);
      end
      OP_EN1: begin
        inputEnable = 1'b1; tick(1);
      end
      default: tick(1);
    endcase
  endtask

  task automatic pop_compare(input int idx);
    exp_t e;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_empty vec%0d actual=0 required=1", idx);
    end else begin
      e = sb_q.pop_front();
      check($sformatf("vec%0d_userInt", idx), {16'h0, userInt}, {16'h0, e.i});
      check($sformatf("vec%0d_digitCount", idx), {29'h0, digitCount}, {29'h0, e.c});
      check($sformatf("vec%0d_ready", idx), {31'h0, ready}, {31'h0, e.r});
    end
  endtask

  initial begin
    exp_t e;
    rst = 1'b0; inputEnable = 1'b0; keyCode = 4'd0;
    keyValid = 1'b0; btnEnter = 1'b0; btnClear = 1'b0;

    // Reset held while inputs toggle randomly
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      inputEnable = 1'($urandom_range(0, 1));
      keyCode     = 4'($urandom_range(0, 15));
      keyValid    = 1'($urandom_range(0, 1));
      btnEnter    = 1'($urandom_range(0, 1));
      btnClear    = 1'($urandom_range(0, 1));
    end
    check("reset_userInt", {16'h0, userInt}, 32'h0);
    check("reset_digitCount", {29'h0, digitCount}, 32'h0);
    check("reset_ready", {31'h0, ready}, 32'h0);

    // Release with the input phase off; a key press must be ignored
    inputEnable = 1'b0; keyValid = 1'b0; btnEnter = 1'b0; btnClear = 1'b0;
    tick(1);
    rst = 1'b1;
    tick(2);
    press_key(4'd5);
    check("idle_userInt", {16'h0, userInt}, 32'h0);
    check("idle_digitCount", {29'h0, digitCount}, 32'h0);
    check("idle_ready", {31'h0, ready}, 32'h0);

    vecs.push_back(mk(OP_EN1,         4'd0,  16'h0000, 3'd0, 1'b0));
    vecs.push_back(mk(OP_KEY,         4'd1,  16'h0001, 3'd1, 1'b0));
    vecs.push_back(mk(OP_KEY,         4'd2,  16'h0012, 3'd2, 1'b0));
    vecs.push_back(mk(OP_KEY,         4'd3,  16'h0123, 3'd3, 1'b0));
    vecs.push_back(mk(OP_KEY,         4'd4,  16'h1234, 3'd4, 1'b0));
    vecs.push_back(mk(OP_ENTER_TIMED, 4'd0,  16'h1234, 3'd4, 1'b1));
    vecs.push_back(mk(OP_KEY,         4'd9,  16'h1234, 3'd4, 1'b1));
    vecs.push_back(mk(OP_ENTER,       4'd0,  16'h1234, 3'd4, 1'b1));
    vecs.push_back(mk(OP_EN0,         4'd0,  16'h1234, 3'd4, 1'b0));
    vecs.push_back(mk(OP_EN1,         4'd0,  16'h0000, 3'd0, 1'b0));
    vecs.push_back(mk(OP_KEY,         4'd7,  16'h0007, 3'd1, 1'b0));
    vecs.push_back(mk(OP_KEY,         4'd8,  16'h0078, 3'd2, 1'b0));
    vecs.push_back(mk(OP_ENTER,       4'd0,  16'h0078, 3'd2, 1'b0));
    vecs.push_back(mk(OP_KEY,         4'd9,  16'h0789, 3'd3, 1'b0));
    vecs.push_back(mk(OP_KEY,         4'd0,  16'h7890, 3'd4, 1'b0));
    vecs.push_back(mk(OP_KEY,         4'd6,  16'h7890, 3'd4, 1'b0));
    vecs.push_back(mk(OP_CLEAR,       4'd0,  16'h0000, 3'd0, 1'b0));
    vecs.push_back(mk(OP_KEY,         4'hB,  16'h0000, 3'd0, 1'b0));
    vecs.push_back(mk(OP_KEY,         4'd4,  16'h0004, 3'd1, 1'b0));
    vecs.push_back(mk(OP_KEY,         4'd3,  16'h0043, 3'd2, 1'b0));
    vecs.push_back(mk(OP_KEY,         4'd2,  16'h0432, 3'd3, 1'b0));
    vecs.push_back(mk(OP_KEY,         4'd1,  16'h4321, 3'd4, 1'b0));
    vecs.push_back(mk(OP_BOTH,        4'd0,  16'h0000, 3'd0, 1'b0));
    vecs.push_back(mk(OP_KEY,         4'd5,  16'h0005, 3'd1, 1'b0));
    vecs.push_back(mk(OP_GLITCH,      4'd9,  16'h0005, 3'd1, 1'b0));
    vecs.push_back(mk(OP_BOUNCE,      4'd6,  16'h0056, 3'd2, 1'b0));

    for (int v = 0; v < vecs.size(); v++) begin
      e.i = vecs[v].exp_int;
      e.c = vecs[v].exp_cnt;
      e.r = vecs[v].exp_rdy;
      sb_q.push_back(e);
      apply(vecs[v]);
      pop_compare(v);
    end

    // Asynchronous reset mid-entry: outputs clear before any clock edge
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_userInt", {16'h0, userInt}, 32'h0);
    check("async_rst_digitCount", {29'h0, digitCount}, 32'h0);
    check("async_rst_ready", {31'h0, ready}, 32'h0);
    tick(3);
    rst = 1'b1;
    tick(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/user_input_loader.md
Name: user_input_loader

Overview:
Upstream feeder of the answer-check and display stages in the memorization game top level.
- Takes raw key events from the keyboard scanner (BCD digit code plus press level) and two raw pushbuttons (enter, clear).
- Synchronizes and debounces all three inputs.
- Assembles four decimal digits into a 16-bit BCD word (userInt).
- Asserts ready once the player commits a full 4-digit entry, during the input phase only.

Parameters:
DEBOUNCE_CYCLES, 1000000, consecutive stable clk cycles before a debounced input changes (10 ms at 100 MHz). Benches use 4.
NUM_DIGITS, 4, digits per entry. Fixed; userInt width is 4*NUM_DIGITS.

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-low reset
inputEnable  input  1  high during the input phase (the inverse of the top level's displayPhase)
keyCode  input  4  digit code from the scanner; must be stable while keyValid is high
keyValid  input  1  raw key-pressed level, asynchronous
btnEnter  input  1  raw enter button, asynchronous
btnClear  input  1  raw clear button, asynchronous
userInt  output  16  entered digits as BCD; first digit in [15:12], last digit in [3:0]
digitCount  output  3  number of digits entered so far, 0..4
ready  output  1  level; entry is committed and valid

Behaviour:
Reset (rst low, asynchronous):
- state=IDLE, userInt=0, digitCount=0, ready=0.
- All synchronizer flops, debounced levels and debounce counters cleared to 0.
- Reset asserted mid-entry discards the partial entry.

Input conditioning:
- keyValid, btnEnter and btnClear each pass through a 2-flop synchronizer, then an independent debouncer.
- Debouncer: a counter runs while the synchronized value differs from the debounced level and resets to 0 whenever they match. When the count reaches DEBOUNCE_CYCLES-1, the debounced level flips and the counter clears.
- A 0->1 transition on a debounced level produces a one-cycle event: keyEv, enterEv or clearEv. Releases produce no event.
- Latency from a clean raw edge to its event: 2 sync cycles + DEBOUNCE_CYCLES + 1.
- keyCode is sampled in the keyEv cycle. Codes 10..15 are ignored (no shift, no count change).

Event priority in the same cycle: clearEv > enterEv > keyEv. Only the highest-priority event acts.

State machine:
- IDLE: all events are ignored and outputs hold their values. On inputEnable=1: go to ENTRY with userInt=0, digitCount=0, ready=0.
- ENTRY (digitCount 0..3):
  - Valid keyEv: userInt <= {userInt[11:0], keyCode}, digitCount+1. If digitCount becomes 4, go to FULL.
  - enterEv: ignored.
- FULL (digitCount=4):
  - keyEv: ignored; no wrap-around, no overwrite.
  - enterEv: ready <= 1, go to DONE.
- DONE: ready stays high, and userInt and digitCount hold. keyEv and enterEv are ignored.
- clearEv in ENTRY, FULL or DONE: userInt=0, digitCount=0, ready=0, go to ENTRY.
- inputEnable=0 in any non-IDLE state: go to IDLE next cycle and clear ready. userInt and digitCount hold. This check takes precedence over every event.

Timing and width rules:
- All outputs are registered; updates are visible one cycle after the event.
- digitCount never exceeds 4.
- ready is never high unless digitCount=4.

Test Plan:
- Reset: hold rst=0 with random inputs toggling -> userInt=0x0000, digitCount=0, ready=0. Release with inputEnable=0, press key 5 -> state stays IDLE, outputs unchanged.
- Normal entry (DEBOUNCE_CYCLES=4, inputEnable=1): press and release keys 1,2,3,4, then enter -> userInt=0x1234 and digitCount=4. ready rises exactly 2+4+1+1 cycles after the btnEnter raw edge.
- Overflow and early enter: enter after digits 7,8 -> ignored (ready=0, digitCount=2). Then press 9,0,6 -> userInt=0x7890, digitCount=4; the 6 is dropped.
- Invalid code and bounce: keyCode=0xB press -> no change. keyValid glitch of 3 cycles -> no event. A 10-cycle bounce train followed by a stable press -> exactly one digit shifted.
- Simultaneous events: clearEv and enterEv in the same cycle while FULL with 0x4321 -> userInt=0, digitCount=0, ready=0, state ENTRY.
- Phase exit and reset mid-entry: drop inputEnable in DONE -> ready=0 next cycle, userInt holds 0x1234. Re-raise inputEnable -> userInt=0. Assert rst asynchronously after 2 digits -> outputs 0 immediately, without waiting for a clock edge.
